// File: rtl/vec_reg_drain.sv
// Drains a range of vector-register elements out as scalar valid/ready beats.
// Optional VEC_REG_DRAIN_REVERSE_EN adds a 'reverse' input for descending index order.
package vec_reg_drain_pkg;
    typedef enum logic [1:0] {
        VEC_DATA_READ_DISABLE = 2'd0,
        VEC_DATA_READ_SCALAR  = 2'd1,
        VEC_DATA_READ_VECTOR  = 2'd2
    } VecDataReadOp_t;
endpackage

module vec_reg_drain
    import vec_reg_drain_pkg::*;
#(
    parameter int unsigned WIDTH           = 128,
    parameter int unsigned WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [WIDTH_ADDR_SIZE-1:0] start_index,
    input  logic [WIDTH_ADDR_SIZE:0]   count,
`ifdef VEC_REG_DRAIN_REVERSE_EN
    input  logic                       reverse,
`endif
    output logic                       busy,
    output logic                       done,
    output VecDataReadOp_t             read_op,
    output logic [WIDTH_ADDR_SIZE-1:0] read_param,
    input  shortreal                   reg_data [WIDTH],
    output logic                       out_valid,
    input  logic                       out_ready,
    output shortreal                   out_data,
    output logic [WIDTH_ADDR_SIZE-1:0] out_index,
    output logic                       out_last
);

    localparam int unsigned CW = WIDTH_ADDR_SIZE + 1;
    localparam logic [WIDTH_ADDR_SIZE-1:0] LastIdx  = WIDTH_ADDR_SIZE'(WIDTH - 1);
    localparam logic [CW-1:0]              CountMax = CW'(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e                     state_q;
    logic [WIDTH_ADDR_SIZE-1:0] idx_q;
    logic [WIDTH_ADDR_SIZE-1:0] idx_nxt;
    logic [CW-1:0]              rem_q;
    logic [CW-1:0]              count_sat;
    logic                       done_zero_q;
    logic                       adv;
`ifdef VEC_REG_DRAIN_REVERSE_EN
    logic                       rev_q;
`endif

    // The output register may reload whenever it is empty or being drained this cycle.
    assign adv       = !out_valid || out_ready;
    assign busy      = (state_q != StIdle);
    assign done      = done_zero_q || (state_q == StFlush && out_valid && out_ready);
    assign count_sat = (count > CountMax) ? CountMax : count;

    // Register read path is combinational, so the issue and the sample share a cycle.
    always_comb begin
        read_op    = VEC_DATA_READ_DISABLE;
        read_param = '0;
        if (state_q == StRun && adv) begin
            read_op    = VEC_DATA_READ_SCALAR;
            read_param = idx_q;
        end
    end

    always_comb begin
        idx_nxt = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
`ifdef VEC_REG_DRAIN_REVERSE_EN
        if (rev_q) begin
            idx_nxt = (idx_q == '0) ? LastIdx : idx_q - 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            rem_q       <= '0;
            done_zero_q <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 0.0;
            out_index   <= '0;
            out_last    <= 1'b0;
`ifdef VEC_REG_DRAIN_REVERSE_EN
            rev_q       <= 1'b0;
`endif
        end else begin
            done_zero_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (count == '0) begin
                            done_zero_q <= 1'b1;
                        end else begin
                            idx_q   <= start_index;
                            rem_q   <= count_sat;
                            state_q <= StRun;
`ifdef VEC_REG_DRAIN_REVERSE_EN
                            rev_q   <= reverse;
`endif
                        end
                    end
                end
                StRun: begin
                    if (adv) begin
                        out_valid <= 1'b1;
                        out_data  <= reg_data[0];
                        out_index <= idx_q;
                        out_last  <= (rem_q == CW'(1));
                        idx_q     <= idx_nxt;
                        rem_q     <= rem_q - 1'b1;
                        if (rem_q == CW'(1)) begin
                            state_q <= StFlush;
                        end
                    end
                end
                StFlush: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vec_reg_drain.sv
// Scoreboard bench for vec_reg_drain: a driver queues expected beats from an index-range
// model, a negedge monitor checks beats, done, stall stability and stalled read ops.
module tb_vec_reg_drain;
    import vec_reg_drain_pkg::*;

    localparam int WIDTH = 8;
    localparam int AW    = 3;

    typedef struct {
        shortreal        data;
        logic [AW-1:0]   idx;
        logic            last;
    } beat_t;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  start_index = '0;
    logic [AW:0]    count = '0;
`ifdef VEC_REG_DRAIN_REVERSE_EN
    logic           reverse = 1'b0;
`endif
    logic           busy;
    logic           done;
    VecDataReadOp_t read_op;
    logic [AW-1:0]  read_param;
    shortreal       reg_data [WIDTH];
    logic           out_valid;
    logic           out_ready = 1'b1;
    shortreal       out_data;
    logic [AW-1:0]  out_index;
    logic           out_last;

    shortreal       regs [WIDTH];
    beat_t          exp_q [$];
    int             n_cmp = 0;
    int             n_err = 0;
    int             zero_req = 0;
    int             zero_ack = 0;

    // Monitor-owned state
    beat_t          e;
    bit             exp_done;
    bit             prev_stall = 0;
    shortreal       pd;
    logic [AW-1:0]  pi;
    logic           pl;

    vec_reg_drain #(.WIDTH(WIDTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .start_index (start_index),
        .count       (count),
`ifdef VEC_REG_DRAIN_REVERSE_EN
        .reverse     (reverse),
`endif
        .busy        (busy),
        .done        (done),
        .read_op     (read_op),
        .read_param  (read_param),
        .reg_data    (reg_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_last    (out_last)
    );

    always #5 clock = ~clock;

    // Vector register model: lane 0 carries the element only while a scalar read is issued.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) reg_data[i] = 0.0;
        if (read_op == VEC_DATA_READ_SCALAR) reg_data[0] = regs[read_param];
    end

    task automatic chk(input string name, input bit ok, input string detail);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            prev_stall = 0;
        end else begin
            exp_done = (zero_req != zero_ack);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("beat", 0, $sformatf("got idx=%0d data=%f, want no beat", out_index,
                        out_data));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat", out_data == e.data && out_index == e.idx && out_last == e.last,
                        $sformatf("got data=%f idx=%0d last=%0b, want data=%f idx=%0d last=%0b",
                        out_data, out_index, out_last, e.data, e.idx, e.last));
                    if (e.last) exp_done = 1;
                end
            end
            if (done || exp_done)
                chk("done", done == exp_done, $sformatf("got done=%0b, want %0b", done, exp_done));
            zero_ack = zero_req;
            if (prev_stall)
                chk("hold", out_valid && out_data == pd && out_index == pi && out_last == pl,
                    $sformatf("got v=%0b data=%f idx=%0d last=%0b, want v=1 data=%f idx=%0d last=%0b",
                    out_valid, out_data, out_index, out_last, pd, pi, pl));
            prev_stall = out_valid && !out_ready;
            if (prev_stall) begin
                pd = out_data;
                pi = out_index;
                pl = out_last;
                chk("stall_read", read_op == VEC_DATA_READ_DISABLE && read_param == '0,
                    $sformatf("got op=%0d param=%0d, want op=0 param=0", read_op, read_param));
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_vals"}, !busy && !done && read_op == VEC_DATA_READ_DISABLE &&
            read_param == '0 && !out_valid && out_data == 0.0 && out_index == '0 && !out_last,
            $sformatf("got busy=%0b done=%0b op=%0d param=%0d v=%0b data=%f idx=%0d last=%0b, want all 0",
            busy, done, read_op, read_param, out_valid, out_data, out_index, out_last));
    endtask

    task automatic fill_regs();
        for (int i = 0; i < WIDTH; i++) regs[i] = shortreal'($urandom_range(0, 4000)) / 4.0;
    endtask

    task automatic push_expect(input int si, input int cnt, input bit rev);
        int    n;
        int    idx;
        beat_t b;
        n = (cnt > WIDTH) ? WIDTH : cnt;
        for (int k = 0; k < n; k++) begin
            idx    = rev ? (((si - k) % WIDTH) + WIDTH) % WIDTH : (si + k) % WIDTH;
            b.data = regs[idx];
            b.idx  = AW'(idx);
            b.last = (k == n - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_job(input int si, input int cnt, input bit rev, input bit rnd);
        int budget;
        push_expect(si, cnt, rev);
        out_ready   = 1'b1;
        start_index = AW'(si);
        count       = (AW + 1)'(cnt);
`ifdef VEC_REG_DRAIN_REVERSE_EN
        reverse     = rev;
`endif
        start       = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        if (cnt == 0) begin
            zero_req++;
            chk("zero_busy", !busy && !out_valid, $sformatf("got busy=%0b v=%0b, want 0 0",
                busy, out_valid));
            @(posedge clock);
            #1;
            chk("zero_busy2", !busy && !out_valid && !done,
                $sformatf("got busy=%0b v=%0b done=%0b, want 0 0 0", busy, out_valid, done));
        end else begin
            chk("latency0", busy && !out_valid, $sformatf("got busy=%0b v=%0b, want 1 0",
                busy, out_valid));
            for (budget = 0; budget < 400; budget++) begin
                if (rnd) out_ready = 1'($urandom_range(0, 1));
                if (busy && $urandom_range(0, 5) == 0) begin
                    start       = 1'b1;
                    start_index = AW'($urandom_range(0, WIDTH - 1));
                    count       = (AW + 1)'($urandom_range(1, 15));
                end
                @(posedge clock);
                #1 start = 1'b0;
                if (budget == 0)
                    chk("latency1", out_valid == 1'b1, $sformatf("got v=%0b, want 1", out_valid));
                if (!busy) break;
            end
            if (budget >= 400) chk("timeout", 0, "got busy after 400 cycles, want job complete");
            out_ready = 1'b1;
        end
        chk("drained", exp_q.size() == 0, $sformatf("got %0d beats outstanding, want 0",
            exp_q.size()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by 1ms, want finish");
        $fatal(1);
    end

    initial begin
        fill_regs();
        #7 check_reset("reset");
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1 check_reset("post_reset");

        for (int i = 0; i < 4; i++) regs[i] = shortreal'(i + 1);
        run_job(0, 4, 0, 0);
        fill_regs();
        run_job(6, 4, 0, 0);
        run_job(3, 0, 0, 0);
        run_job(2, WIDTH + 5, 0, 0);

        repeat (25) begin
            bit rev;
            fill_regs();
            rev = 0;
`ifdef VEC_REG_DRAIN_REVERSE_EN
            rev = 1'($urandom_range(0, 1));
`endif
            run_job($urandom_range(0, WIDTH - 1), $urandom_range(0, 15), rev, 1);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end

        // Abort an 8-element job right after its second handshake.
        fill_regs();
        push_expect(4, 8, 0);
        out_ready   = 1'b1;
        start_index = AW'(4);
        count       = (AW + 1)'(8);
        start       = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b0;
        #1 check_reset("abort");
        chk("abort_beats", exp_q.size() == 6, $sformatf("got %0d beats left, want 6",
            exp_q.size()));
        exp_q.delete();
        @(posedge clock);
        #2 check_reset("abort_hold");
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        fill_regs();
        run_job(5, 8, 0, 1);

`ifdef VEC_REG_DRAIN_REVERSE_EN
        fill_regs();
        run_job(1, 3, 1, 0);
`endif

        repeat (3) @(posedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
